// File: rtl/nts_dispatcher_mbuf.sv
// Captures MAC RX frames into a ring of packet buffers and presents committed frames in order to the parser.
// One-cycle word read latency; frames that find no EMPTY buffer, overflow, or end bad are dropped and counted.
module nts_dispatcher_mbuf #(
  parameter int ADDR_WIDTH   = 3,
  parameter int BUFFERS_LOG2 = 1
) (
  input  logic                    i_clk,
  input  logic                    i_areset_n,
  input  logic [7:0]              i_rx_data_valid,
  input  logic [63:0]             i_rx_data,
  input  logic                    i_rx_bad_frame,
  input  logic                    i_rx_good_frame,
  input  logic                    i_process_frame,
  output logic                    o_dispatch_packet_available,
  input  logic                    i_dispatch_packet_read_discard,
  output logic [ADDR_WIDTH-1:0]   o_dispatch_counter,
  output logic [7:0]              o_dispatch_data_valid,
  output logic                    o_dispatch_fifo_empty,
  input  logic                    i_dispatch_fifo_rd_en,
  output logic [63:0]             o_dispatch_fifo_rd_data,
  output logic [31:0]             o_frames_dropped,
  output logic [BUFFERS_LOG2:0]   o_buffers_used
);

  localparam int NB    = 1 << BUFFERS_LOG2;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {ST_EMPTY, ST_WRITING, ST_WAIT, ST_FULL} buf_state_t;
  typedef logic [BUFFERS_LOG2-1:0] bidx_t;
  typedef logic [ADDR_WIDTH:0]     ptr_t;

  buf_state_t            buf_state [NB];
  logic [ADDR_WIDTH-1:0] last_idx  [NB];
  logic [7:0]            last_vld  [NB];
  logic [63:0]           mem       [NB*DEPTH];

  bidx_t                 wr_idx, rd_idx;
  ptr_t                  wr_ptr, rd_ptr;
  logic                  in_frame, nobuf_frame, overflow;
  logic                  avail, fifo_empty;
  logic [63:0]           rd_data;
  logic [31:0]           dropped;
  logic [BUFFERS_LOG2:0] used;

  logic                  beat, end_beat, commit, start, pend_drop, claim, nobuf;
  logic                  store, ovf_acc, end_drop, discard, rd_fire, avail_n;
  bidx_t                 wr_idx_n;
  ptr_t                  ptr_base, rd_ptr_n;
  logic [1:0]            drop_inc;
  logic [32:0]           drop_sum;
  logic [BUFFERS_LOG2:0] used_n;

  always_comb begin
    beat      = |i_rx_data_valid;
    end_beat  = beat && (i_rx_bad_frame || i_rx_good_frame);
    commit    = i_process_frame && (buf_state[wr_idx] == ST_WAIT);
    wr_idx_n  = commit ? wr_idx + bidx_t'(1) : wr_idx;
    start     = beat && !in_frame;
    // A new frame landing on an uncommitted WAIT buffer evicts the pending frame
    pend_drop = start && !commit && (buf_state[wr_idx] == ST_WAIT);
    claim     = start && ((buf_state[wr_idx_n] == ST_EMPTY) || pend_drop);
    nobuf     = start ? !claim : nobuf_frame;
    ptr_base  = start ? '0 : wr_ptr;
    store     = beat && !nobuf && !ptr_base[ADDR_WIDTH];
    ovf_acc   = (!start && overflow) || (beat && !nobuf && ptr_base[ADDR_WIDTH]);
    end_drop  = end_beat && (nobuf || i_rx_bad_frame || ovf_acc);
    drop_inc  = {1'b0, pend_drop} + {1'b0, end_drop};
    drop_sum  = {1'b0, dropped} + 33'(drop_inc);

    discard   = i_dispatch_packet_read_discard && avail;
    rd_fire   = i_dispatch_fifo_rd_en && !fifo_empty;
    rd_ptr_n  = discard ? '0 : (rd_fire ? rd_ptr + ptr_t'(1) : rd_ptr);
    avail_n   = !discard && ((buf_state[rd_idx] == ST_FULL) || (commit && (wr_idx == rd_idx)));

    used_n = '0;
    for (int i = 0; i < NB; i++) begin
      if (buf_state[i] == ST_WAIT || buf_state[i] == ST_FULL)
        used_n = used_n + (BUFFERS_LOG2+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (store)
      mem[{wr_idx_n, ptr_base[ADDR_WIDTH-1:0]}] <= i_rx_data;
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      for (int i = 0; i < NB; i++) begin
        buf_state[i] <= ST_EMPTY;
        last_idx[i]  <= '0;
        last_vld[i]  <= '0;
      end
      wr_idx      <= '0;
      rd_idx      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      in_frame    <= 1'b0;
      nobuf_frame <= 1'b0;
      overflow    <= 1'b0;
      avail       <= 1'b0;
      fifo_empty  <= 1'b1;
      rd_data     <= '0;
      dropped     <= '0;
      used        <= '0;
    end else begin
      wr_idx <= wr_idx_n;
      if (commit)
        buf_state[wr_idx] <= ST_FULL;

      if (beat) begin
        overflow <= ovf_acc;
        if (store) begin
          wr_ptr             <= ptr_base + ptr_t'(1);
          last_idx[wr_idx_n] <= ptr_base[ADDR_WIDTH-1:0];
          last_vld[wr_idx_n] <= i_rx_data_valid;
        end else begin
          wr_ptr <= ptr_base;
        end
        if (end_beat) begin
          in_frame    <= 1'b0;
          nobuf_frame <= 1'b0;
          if (!nobuf)
            buf_state[wr_idx_n] <= end_drop ? ST_EMPTY : ST_WAIT;
        end else begin
          in_frame    <= 1'b1;
          nobuf_frame <= nobuf;
          if (claim)
            buf_state[wr_idx_n] <= ST_WRITING;
        end
      end

      if (discard) begin
        buf_state[rd_idx] <= ST_EMPTY;
        rd_idx            <= rd_idx + bidx_t'(1);
      end
      if (rd_fire)
        rd_data <= mem[{rd_idx, rd_ptr[ADDR_WIDTH-1:0]}];
      rd_ptr     <= rd_ptr_n;
      avail      <= avail_n;
      // Empty once the pointer passes the last word of the presented packet
      fifo_empty <= !avail_n || (rd_ptr_n > {1'b0, last_idx[rd_idx]});

      dropped <= drop_sum[32] ? '1 : drop_sum[31:0];
      used    <= used_n;
    end
  end

  assign o_dispatch_packet_available = avail;
  assign o_dispatch_counter          = avail ? last_idx[rd_idx] : '0;
  assign o_dispatch_data_valid       = avail ? last_vld[rd_idx] : '0;
  assign o_dispatch_fifo_empty       = fifo_empty;
  assign o_dispatch_fifo_rd_data     = rd_data;
  assign o_frames_dropped            = dropped;
  assign o_buffers_used              = used;

endmodule

// File: doc/nts_dispatcher_mbuf.md
Name: nts_dispatcher_mbuf

Overview:
Parametrised multi-buffer successor to the single-buffer RX dispatcher front. It captures 64-bit RX frames from the MAC into a ring of 2^BUFFERS_LOG2 packet buffers, each 2^ADDR_WIDTH words deep. A frame is held until the parser commits it with i_process_frame. Committed buffers are presented in order to the downstream parser through the same available/counter/FIFO-read interface as before. Adds back-to-back frame capture while a packet is being read, overflow and bad-frame dropping, and drop/occupancy statistics.

Parameters:
ADDR_WIDTH, 3, log2 of words per buffer (depth 2^ADDR_WIDTH x 64 bit)
BUFFERS_LOG2, 1, log2 of buffer count (default 2 buffers)

Ports:
i_clk  in  1  clock
i_areset_n  in  1  asynchronous active-low reset
i_rx_data_valid  in  8  byte-valid mask of the RX beat; 0 = no beat
i_rx_data  in  64  RX beat data
i_rx_bad_frame  in  1  current beat ends a bad frame
i_rx_good_frame  in  1  current beat ends a good frame
i_process_frame  in  1  commit the frame awaiting processing
o_dispatch_packet_available  out  1  read buffer holds a committed packet
i_dispatch_packet_read_discard  in  1  release the current read buffer
o_dispatch_counter  out  ADDR_WIDTH  index of the last word of the read packet
o_dispatch_data_valid  out  8  byte-valid mask of the last word
o_dispatch_fifo_empty  out  1  all words of the read packet consumed
i_dispatch_fifo_rd_en  in  1  read next word
o_dispatch_fifo_rd_data  out  64  word read
o_frames_dropped  out  32  saturating count of dropped frames
o_buffers_used  out  BUFFERS_LOG2+1  buffers in WAIT or FULL state

Behaviour:
- One clock. Reset is asynchronous and active-low. Reset clears all state, pointers and counters immediately, including mid-frame and mid-read. Reset values:
  - available=0, counter=0, data_valid=0, fifo_empty=1, rd_data=0, dropped=0, used=0.
- Per-buffer state is EMPTY, WRITING, WAIT, or FULL. A write index and a read index each wrap modulo 2^BUFFERS_LOG2.
- Write side:
  - A beat is any cycle with i_rx_data_valid!=0.
  - The first beat of a frame claims the write buffer only if it is EMPTY. It goes to WRITING and the word pointer is set to 0.
  - If the write buffer is not EMPTY, the whole frame is dropped.
  - Each beat is stored at the word pointer, which then increments.
  - A beat beyond 2^ADDR_WIDTH words sets a sticky overflow flag and is not stored. The pointer does not wrap.
  - The last beat's index and valid mask are latched with the frame.
  - An end beat is a beat with good or bad asserted. If both are set, bad wins.
  - Bad end, overflow, or no-buffer: the frame is dropped, the buffer returns to EMPTY, and dropped increments.
  - Good end with no error: the buffer goes to WAIT.
  - WAIT plus i_process_frame (any later cycle): the buffer goes to FULL and the write index advances.
  - WAIT plus a new beat without i_process_frame: the pending frame is dropped and counted, and the beat starts a new frame in the same buffer.
  - i_process_frame outside WAIT is ignored.
- Read side:
  - o_dispatch_packet_available is 1 when the read-index buffer is FULL. It rises the cycle after i_process_frame is sampled.
  - counter and data_valid show the latched values of the read buffer while available=1, and 0 otherwise.
  - rd_en with fifo_empty=0: on the next edge, rd_data is loaded with the word at the read pointer, the pointer increments, and fifo_empty=1 once the pointer passes counter. One cycle of read latency.
  - rd_en with fifo_empty=1 is ignored and rd_data holds.
  - i_dispatch_packet_read_discard while available: the buffer goes to EMPTY, the read index advances, the read pointer resets to 0, and available deasserts the next cycle. If the next buffer is already FULL, it is presented the cycle after that.
  - Discard while not available is ignored.
- Capture into one buffer while another is being read is fully concurrent.
- o_frames_dropped saturates at 0xFFFFFFFF. o_buffers_used is registered.

Test Plan:
- Reset, then a 3-beat good frame (0x0102030405060708, 0x0000000220202020, 0x0000000330303030, valid=0xFF, good on beat 3), then process_frame -> available=1 a cycle after process, counter=2, data_valid=0xFF. Three rd_en reads return the words in order, fifo_empty=1 with the third word. Discard -> available=0, used=0.
- Two good frames back-to-back, both processed -> used=2. Read and discard the first -> the second is presented with its own counter and data. A third frame arriving while both buffers are FULL -> dropped=1.
- A 9-beat frame with ADDR_WIDTH=3 ending good -> not committed, dropped=1, buffer EMPTY.
- A frame with good and bad asserted on the last beat -> dropped=1, available stays 0.
- A frame in WAIT followed by a new frame with no process_frame -> dropped=1. The new frame is committed normally, with last data_valid=0x0F giving data_valid=0x0F.
- i_areset_n low during a read of the second word -> all outputs return to reset values asynchronously. The next frame is captured from buffer 0.
